// File: rtl/ppu_lcd_timing_regs.sv
// PPU register file (FF40-FF4B) and LCD dot/line timing generator.
// Define PPU_STAT_BLOCKING_EN to make STAT fire only on the OR-line 0->1 edge.
module ppu_lcd_timing_regs #(
    parameter logic [15:0] BASE_ADDR     = 16'hFF40,
    parameter int          DOTS_PER_LINE = 456,
    parameter int          OAM_DOTS      = 80,
    parameter int          DRAW_DOTS     = 172,
    parameter int          VISIBLE_LINES = 144,
    parameter int          TOTAL_LINES   = 154
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_a,
    input  logic [7:0]  mmio_din,
    input  logic        mmio_wr,
    output logic [7:0]  mmio_dout,
    output logic [7:0]  lcdc,
    output logic [7:0]  scy,
    output logic [7:0]  scx,
    output logic [7:0]  bgp,
    output logic [7:0]  obp0,
    output logic [7:0]  obp1,
    output logic [7:0]  wy,
    output logic [7:0]  wx,
    output logic [7:0]  ly,
    output logic [1:0]  ppu_mode,
    output logic [8:0]  dot,
    output logic        vblank_interrupt,
    output logic        statline_interrupt
);

    typedef enum logic [1:0] {
        HBLANK   = 2'd0,
        VBLANK   = 2'd1,
        OAM_SCAN = 2'd2,
        DRAW     = 2'd3
    } mode_t;

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
    localparam logic [8:0] DRAW_END = 9'(OAM_DOTS + DRAW_DOTS);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);

    mode_t       mode_q;
    mode_t       mode_d;
    logic [7:0]  lyc;
    logic [3:0]  stat_en;
    logic        lyc_eq;
    logic [3:0]  src_q;
    logic [3:0]  src_d;
    logic [15:0] off;
    logic        hit;
    logic        wr_en;
    logic [7:0]  lcdc_d;
    logic [3:0]  en_d;
    logic        on_d;
    logic        was_on;
    logic        wrap;
    logic        vblank_d;
    logic        lyc_eq_d;
    logic        stat_pulse_d;
    logic [8:0]  dot_d;
    logic [7:0]  ly_d;
    logic [7:0]  rd_data;

    assign off    = mmio_a - BASE_ADDR;
    assign hit    = off < 16'd12;
    assign wr_en  = mmio_wr & hit;
    assign lcdc_d = (wr_en && off[3:0] == 4'd0) ? mmio_din : lcdc;
    assign en_d   = (wr_en && off[3:0] == 4'd1) ? mmio_din[6:3] : stat_en;
    assign on_d   = lcdc_d[7];
    assign was_on = lcdc[7];

    // Turning the panel on restarts at line 0 dot 0; counting resumes a cycle later.
    always_comb begin
        dot_d = dot;
        ly_d  = ly;
        wrap  = 1'b0;
        if (!on_d || !was_on) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (dot == DOT_LAST) begin
            dot_d = '0;
            wrap  = 1'b1;
            ly_d  = (ly == LY_LAST) ? 8'd0 : 8'(ly + 8'd1);
        end else begin
            dot_d = 9'(dot + 9'd1);
        end
    end

    assign vblank_d = on_d & was_on & wrap & (ly_d == LY_VIS);

    always_comb begin
        mode_d = HBLANK;
        if (!on_d)
            mode_d = HBLANK;
        else if (ly_d >= LY_VIS)
            mode_d = VBLANK;
        else if (dot_d < OAM_END)
            mode_d = OAM_SCAN;
        else if (dot_d < DRAW_END)
            mode_d = DRAW;
        else
            mode_d = HBLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            mode_q <= OAM_SCAN;
        else
            mode_q <= mode_d;
    end

    assign ppu_mode = mode_q;
    assign lyc_eq_d = (ly_d == lyc);

    // The oam source also fires on VBLANK entry, matching DMG hardware.
    assign src_d = on_d ? {en_d[3] & lyc_eq_d,
                           en_d[2] & ((mode_d == OAM_SCAN) | vblank_d),
                           en_d[1] & (mode_d == VBLANK),
                           en_d[0] & (mode_d == HBLANK)} : 4'd0;

`ifdef PPU_STAT_BLOCKING_EN
    assign stat_pulse_d = (|src_d) & ~(|src_q);
`else
    assign stat_pulse_d = |(src_d & ~src_q);
`endif

    always_comb begin
        rd_data = 8'hFF;
        if (hit) begin
            case (off[3:0])
                4'd0:    rd_data = lcdc;
                4'd1:    rd_data = {1'b1, stat_en, lyc_eq, mode_q};
                4'd2:    rd_data = scy;
                4'd3:    rd_data = scx;
                4'd4:    rd_data = ly;
                4'd5:    rd_data = lyc;
                4'd7:    rd_data = bgp;
                4'd8:    rd_data = obp0;
                4'd9:    rd_data = obp1;
                4'd10:   rd_data = wy;
                4'd11:   rd_data = wx;
                default: rd_data = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lcdc               <= 8'h91;
            stat_en            <= '0;
            scy                <= '0;
            scx                <= '0;
            lyc                <= '0;
            bgp                <= 8'hFC;
            obp0               <= '0;
            obp1               <= '0;
            wy                 <= '0;
            wx                 <= '0;
            ly                 <= '0;
            dot                <= '0;
            lyc_eq             <= 1'b0;
            src_q              <= '0;
            vblank_interrupt   <= 1'b0;
            statline_interrupt <= 1'b0;
            mmio_dout          <= 8'hFF;
        end else begin
            lcdc    <= lcdc_d;
            stat_en <= en_d;
            if (wr_en) begin
                case (off[3:0])
                    4'd2:    scy  <= mmio_din;
                    4'd3:    scx  <= mmio_din;
                    4'd5:    lyc  <= mmio_din;
                    4'd7:    bgp  <= mmio_din;
                    4'd8:    obp0 <= mmio_din;
                    4'd9:    obp1 <= mmio_din;
                    4'd10:   wy   <= mmio_din;
                    4'd11:   wx   <= mmio_din;
                    default: ;
                endcase
            end
            dot                <= dot_d;
            ly                 <= ly_d;
            lyc_eq             <= lyc_eq_d;
            src_q              <= src_d;
            vblank_interrupt   <= vblank_d;
            statline_interrupt <= stat_pulse_d;
            mmio_dout          <= rd_data;
        end
    end

endmodule

// File: tb/tb_ppu_lcd_timing_regs.sv
// Randomised bench for ppu_lcd_timing_regs against a frame-position model.
// Small timing: 20 dots/line, 4 OAM, 6 draw, 3 visible, 5 total lines.
module tb_ppu_lcd_timing_regs;

    localparam int DOTS  = 20;
    localparam int OAM   = 4;
    localparam int DRAW  = 6;
    localparam int VIS   = 3;
    localparam int TOTAL = 5;
    localparam logic [15:0] BASE = 16'hFF40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mmio_a = BASE;
    logic [7:0]  mmio_din = 8'h00;
    logic        mmio_wr = 1'b0;
    logic [7:0]  mmio_dout;
    logic [7:0]  lcdc, scy, scx, bgp, obp0, obp1, wy, wx, ly;
    logic [1:0]  ppu_mode;
    logic [8:0]  dot;
    logic        vblank_interrupt;
    logic        statline_interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ppu_lcd_timing_regs #(
        .BASE_ADDR    (BASE),
        .DOTS_PER_LINE(DOTS),
        .OAM_DOTS     (OAM),
        .DRAW_DOTS    (DRAW),
        .VISIBLE_LINES(VIS),
        .TOTAL_LINES  (TOTAL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mmio_a            (mmio_a),
        .mmio_din          (mmio_din),
        .mmio_wr           (mmio_wr),
        .mmio_dout         (mmio_dout),
        .lcdc              (lcdc),
        .scy               (scy),
        .scx               (scx),
        .bgp               (bgp),
        .obp0              (obp0),
        .obp1              (obp1),
        .wy                (wy),
        .wx                (wx),
        .ly                (ly),
        .ppu_mode          (ppu_mode),
        .dot               (dot),
        .vblank_interrupt  (vblank_interrupt),
        .statline_interrupt(statline_interrupt)
    );

    // Reference model: the frame is a single position t in [0, DOTS*TOTAL).
    logic [7:0] m_reg [12];
    int         m_t;
    int         m_ly;
    int         m_dot;
    int         m_mode;
    bit         m_eq;
    bit [3:0]   m_src;
    bit         m_vbl;
    bit         m_stat;
    logic [7:0] m_dout;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        int o;
        o = int'(a) - int'(BASE);
        if (o < 0 || o > 11 || o == 6) return 8'hFF;
        if (o == 1) return {1'b1, m_reg[1][6:3], m_eq, 2'(m_mode)};
        if (o == 4) return 8'(m_ly);
        return m_reg[o];
    endfunction

    task automatic model_edge(input logic r, input logic [15:0] a,
                              input logic [7:0] d, input logic w);
        int o;
        bit prev_on, on;
        logic [7:0] old_lyc;
        bit [3:0] en, src;
        if (!r) begin
            for (int i = 0; i < 12; i++) m_reg[i] = 8'h00;
            m_reg[0] = 8'h91;
            m_reg[7] = 8'hFC;
            m_t = 0; m_ly = 0; m_dot = 0; m_mode = 2;
            m_eq = 0; m_src = 0; m_vbl = 0; m_stat = 0;
            m_dout = 8'hFF;
            return;
        end
        m_dout  = m_read(a);
        prev_on = m_reg[0][7];
        old_lyc = m_reg[5];
        o = int'(a) - int'(BASE);
        if (w && o >= 0 && o <= 11 && o != 4 && o != 6)
            m_reg[o] = (o == 1) ? {1'b0, d[6:3], 3'b000} : d;
        on    = m_reg[0][7];
        m_vbl = 0;
        if (!on || !prev_on) begin
            m_t = 0;
        end else begin
            m_t   = (m_t + 1) % (DOTS * TOTAL);
            m_vbl = (m_t == VIS * DOTS);
        end
        m_ly  = m_t / DOTS;
        m_dot = m_t % DOTS;
        if (!on) m_mode = 0;
        else if (m_ly >= VIS) m_mode = 1;
        else if (m_dot < OAM) m_mode = 2;
        else if (m_dot < OAM + DRAW) m_mode = 3;
        else m_mode = 0;
        m_eq = (m_ly == int'(old_lyc));
        en   = m_reg[1][6:3];
        src  = 4'd0;
        if (on)
            src = {en[3] & m_eq, en[2] & (m_mode == 2 || m_vbl),
                   en[1] & (m_mode == 1), en[0] & (m_mode == 0)};
`ifdef PPU_STAT_BLOCKING_EN
        m_stat = (src != 0) && (m_src == 0);
`else
        m_stat = (src & ~m_src) != 0;
`endif
        m_src = src;
    endtask

    task automatic step(input logic r, input logic [15:0] a,
                        input logic [7:0] d, input logic w);
        rst = r; mmio_a = a; mmio_din = d; mmio_wr = w;
        @(posedge clk);
        model_edge(r, a, d, w);
        #1;
        check("dout", 32'(mmio_dout), 32'(m_dout));
        check("ly", 32'(ly), 32'(m_ly));
        check("dot", 32'(dot), 32'(m_dot));
        check("mode", 32'(ppu_mode), 32'(m_mode));
        check("vblank_irq", 32'(vblank_interrupt), 32'(m_vbl));
        check("stat_irq", 32'(statline_interrupt), 32'(m_stat));
        check("lcdc", 32'(lcdc), 32'(m_reg[0]));
        check("scy_scx", {16'h0, scy, scx}, {16'h0, m_reg[2], m_reg[3]});
        check("pal", {8'h0, bgp, obp0, obp1},
              {8'h0, m_reg[7], m_reg[8], m_reg[9]});
        check("win", {16'h0, wy, wx}, {16'h0, m_reg[10], m_reg[11]});
    endtask

    task automatic idle(input logic [15:0] a);
        step(1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, BASE, 8'h00, 1'b0);
    endtask

    int c_m0, c_m1, c_m2, c_m3, c_vbl, c_stat, vbl_ly, vbl_dot, guard;
    bit prev_pulse;
    logic [15:0] ra;
    logic [7:0]  rd;

    initial begin
        do_reset();
        do_reset();
        check("rst_ly", 32'(ly), 32'd0);
        check("rst_dot", 32'(dot), 32'd0);
        check("rst_mode", 32'(ppu_mode), 32'd2);
        check("rst_dout", 32'(mmio_dout), 32'hFF);
        check("rst_irq", {vblank_interrupt, statline_interrupt}, 32'd0);
        idle(16'hFF40); check("rd_lcdc", 32'(mmio_dout), 32'h91);
        idle(16'hFF47); check("rd_bgp", 32'(mmio_dout), 32'hFC);
        idle(16'hFF44); check("rd_ly", 32'(mmio_dout), 32'h00);
        idle(16'hFF46); check("rd_dma", 32'(mmio_dout), 32'hFF);
        idle(16'hFF4C); check("rd_oor", 32'(mmio_dout), 32'hFF);

        // One whole frame of mode occupancy and the single vblank pulse.
        do_reset();
        c_m0 = 0; c_m1 = 0; c_m2 = 0; c_m3 = 0; c_vbl = 0;
        vbl_ly = -1; vbl_dot = -1;
        for (int i = 0; i < DOTS * TOTAL; i++) begin
            idle(BASE);
            case (ppu_mode)
                2'd0: c_m0++;
                2'd1: c_m1++;
                2'd2: c_m2++;
                default: c_m3++;
            endcase
            if (vblank_interrupt) begin
                c_vbl++; vbl_ly = int'(ly); vbl_dot = int'(dot);
            end
        end
        check("cnt_oam", 32'(c_m2), 32'd12);
        check("cnt_draw", 32'(c_m3), 32'd18);
        check("cnt_hblank", 32'(c_m0), 32'd30);
        check("cnt_vblank", 32'(c_m1), 32'd40);
        check("vbl_count", 32'(c_vbl), 32'd1);
        check("vbl_pos", {vbl_ly[15:0], vbl_dot[15:0]}, {16'd3, 16'd0});
        check("ly_wrap", 32'(ly), 32'd0);

        // LYC coincidence interrupt and STAT readback.
        do_reset();
        wr(16'hFF45, 8'h02);
        wr(16'hFF41, 8'h40);
        c_stat = 0; prev_pulse = 0;
        for (int i = 0; i < DOTS * TOTAL - 2; i++) begin
            idle(16'hFF41);
            if (prev_pulse) check("stat_rd", 32'(mmio_dout), 32'hC6);
            prev_pulse = statline_interrupt;
            if (statline_interrupt) begin
                c_stat++;
                check("lyc_pulse_ly", 32'(ly), 32'd2);
            end
        end
        check("lyc_pulses", 32'(c_stat), 32'd1);

        // LY is read-only; STAT low bits come from hardware.
        do_reset();
        for (int i = 0; i < 5; i++) idle(BASE);
        wr(16'hFF44, 8'h55);
        check("ly_ro", 32'(ly), 32'd0);
        idle(16'hFF44);
        check("ly_ro_rd", 32'(mmio_dout), 32'h00);
        wr(16'hFF41, 8'hFF);
        guard = 0;
        while (m_t != 14 && guard < 200) begin idle(BASE); guard++; end
        check("reach_t14", 32'(guard < 200), 32'd1);
        idle(16'hFF41);
        check("stat_ff_rd", 32'(mmio_dout), 32'hFC);

        // LCD off mid-line, then back on.
        do_reset();
        for (int i = 0; i < 25; i++) idle(BASE);
        wr(16'hFF40, 8'h11);
        check("off_ly", 32'(ly), 32'd0);
        check("off_dot", 32'(dot), 32'd0);
        check("off_mode", 32'(ppu_mode), 32'd0);
        c_stat = 0;
        for (int i = 0; i < 30; i++) begin
            idle(BASE);
            c_stat += int'(statline_interrupt) + int'(vblank_interrupt);
        end
        check("off_irqs", 32'(c_stat), 32'd0);
        wr(16'hFF40, 8'h91);
        check("on_mode", 32'(ppu_mode), 32'd2);
        check("on_dot", 32'(dot), 32'd0);
        idle(BASE);
        check("on_dot1", 32'(dot), 32'd1);

        // LYC source holding the line while HBLANK source rises.
        do_reset();
        wr(16'hFF45, 8'h01);
        wr(16'hFF41, 8'h48);
        guard = 0;
        while (m_t != 20 && guard < 200) begin idle(BASE); guard++; end
        check("reach_t20", 32'(guard < 200), 32'd1);
        c_stat = 0;
        for (int i = 0; i < 19; i++) begin
            idle(BASE);
            c_stat += int'(statline_interrupt);
        end
`ifdef PPU_STAT_BLOCKING_EN
        check("hblank_blocked", 32'(c_stat), 32'd0);
`else
        check("hblank_pulse", 32'(c_stat), 32'd1);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 7) == 0) begin
                ra = BASE + 16'($urandom_range(0, 12));
                rd = 8'($urandom);
                if (ra == BASE) rd[7] = ($urandom_range(0, 9) != 0);
                wr(ra, rd);
            end else begin
                ra = BASE - 16'd2 + 16'($urandom_range(0, 16));
                idle(ra);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
